mem_pattern_master: RTL and testbench
=====================================

MEM_PATTERN_MASTER -- requirements
Module: mem_pattern_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: word-address width of the memory port.
REQ-002 SHALL have parameter SEED, default 32'h0000_0001: pattern start value.
REQ-003 SHALL have ports clk (in, 1, clock) and reset_n (in, 1, reset); one clock; reset is asynchronous and active-low.
REQ-004 SHALL have control ports: start (in, 1, begin test); abort (in, 1, stop test); base (in, ADDR_W, first word address); length (in, ADDR_W+1, word count).
REQ-005 SHALL have status ports: busy (out, 1); done (out, 1, one-cycle pulse); err_count (out, ADDR_W+1, mismatch count); first_err_addr (out, ADDR_W, address of first mismatch); err_flag (out, 1, any mismatch).
REQ-006 SHALL have memory-master ports: address (out, ADDR_W); byteenable (out, 4); chipselect (out, 1); write (out, 1); writedata (out, 32); clken (out, 1); readdata (in, 32).

Function
REQ-007 SHALL implement states IDLE, WRITE, READ, DRAIN, DONE.
REQ-008 In IDLE, start=1 with length=0 SHALL go to DONE with no memory access; with length>0, it SHALL latch base and length, load pattern = SEED, and go to WRITE.
REQ-009 In WRITE, each cycle SHALL drive chipselect=1, write=1, byteenable=4'hF, address=base+i, writedata=pattern(i) for i = 0..length-1; after the last word it SHALL go to READ.
REQ-010 In READ, each cycle SHALL drive chipselect=1, write=0, address=base+i, i = 0..length-1; after the last issue it SHALL go to DRAIN.
REQ-011 Read latency SHALL be exactly 1 cycle: readdata sampled in cycle N+1 is compared with the expected pattern for the address issued in cycle N. One read issues per cycle, pipelined.
REQ-012 DRAIN SHALL last one cycle to compare the final word, then go to DONE; DONE SHALL pulse done for one cycle and return to IDLE.
REQ-013 Address arithmetic SHALL be modulo 2^ADDR_W, wrapping from the top word to 0. length = 2^ADDR_W covers all words once.
REQ-014 On mismatch, err_count SHALL increment, saturating at all-ones. On the first mismatch of a run, first_err_addr SHALL capture the address and err_flag SHALL set.
REQ-015 err_count, err_flag and first_err_addr SHALL clear on accepted start and hold after done until the next start.
REQ-016 busy SHALL be 1 in WRITE, READ and DRAIN, and 0 otherwise; start while busy SHALL be ignored.
REQ-017 abort=1 in any busy state SHALL deassert chipselect and write in the same cycle (combinational gate). The FSM SHALL enter IDLE at the next edge, discard any pending compare, and emit no done; abort has priority over start.
REQ-018 In IDLE and DONE: chipselect=0, write=0, byteenable=4'h0, address=0, writedata=0. clken SHALL be constant 1.

Reset
REQ-019 reset_n=0 SHALL asynchronously force state IDLE. All outputs SHALL take these values: busy=0, done=0, err_count=0, err_flag=0, first_err_addr=0, chipselect=0, write=0, byteenable=0, address=0, writedata=0, clken=1.
REQ-020 Reset asserted mid-test SHALL abandon the run with no done pulse; the first start after reset_n rises SHALL behave as from power-up.

Configuration
REQ-021 Macro MEM_PATTERN_LFSR_EN defined: pattern(0)=SEED, and pattern(i+1) SHALL be pattern(i) advanced one step of a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1. The LFSR SHALL reload SEED at READ entry.
REQ-022 Macro MEM_PATTERN_LFSR_EN undefined: pattern(i) = SEED + i, modulo 2^32. No LFSR logic SHALL be synthesized.

Verification
REQ-023 base=0x0010, length=4, clean memory, macro undefined -> writes 0x1..0x4 to addresses 0x10..0x13; reads match; done pulses 10 cycles after start (4 write + 4 read + drain + DONE); err_count=0.
REQ-024 base=0xFFFE, length=4 -> addresses issued FFFE, FFFF, 0000, 0001 in both phases; err_count=0.
REQ-025 Memory model corrupts address 0x0012 on readback (bit 0 flipped), base=0x0010, length=8 -> err_count=1, first_err_addr=0x0012, err_flag=1.
REQ-026 abort asserted on the 3rd WRITE cycle -> chipselect=0 that cycle; busy=0 next cycle; no done; the next start runs normally.
REQ-027 length=0 -> no chipselect; done pulses 1 cycle after start. reset_n low mid-READ -> all outputs at reset values immediately.
REQ-028 With MEM_PATTERN_LFSR_EN, SEED=1, length=3 -> writedata 0x00000001, then two LFSR successors; readback passes with err_count=0.

Source files
------------

// File: rtl/mem_pattern_master_if.sv
// mem_pattern_master_if -- word-addressed memory port driven by mem_pattern_master.
//   address/byteenable/chipselect/write/writedata/clken : master -> memory
//   readdata                                           : memory -> master (1-cycle latency)
// Parameter ADDR_W: word-address width.
interface mem_pattern_master_if #(
  parameter int ADDR_W = 16
) ();
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic              chipselect;
  logic              write;
  logic [31:0]       writedata;
  logic              clken;
  logic [31:0]       readdata;

  modport master (
    output address, byteenable, chipselect, write, writedata, clken,
    input  readdata
  );

  modport slave (
    input  address, byteenable, chipselect, write, writedata, clken,
    output readdata
  );
endinterface

// File: rtl/mem_pattern_master.sv
// mem_pattern_master -- memory test master. Writes a pattern to `length` words
// starting at `base`, reads them back (1-cycle read latency, one read per cycle)
// and counts mismatches.
//   clk, reset_n        : clock, async active-low reset
//   start, abort        : begin / cancel a test (abort gates the bus combinationally)
//   base, length        : first word address, word count (length = 2^ADDR_W covers all)
//   busy, done          : running (WRITE/READ/DRAIN), one-cycle completion pulse
//   err_count/err_flag/first_err_addr : saturating mismatch count, sticky flag, first bad address
//   mem                 : memory master port (mem_pattern_master_if.master)
// Build option: define MEM_PATTERN_LFSR_EN to use a 32-bit Galois LFSR pattern
// (x^32+x^22+x^2+x+1) instead of the default incrementing SEED+i pattern.
module mem_pattern_master #(
  parameter int          ADDR_W = 16,
  parameter logic [31:0] SEED   = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              err_flag,
  mem_pattern_master_if.master mem
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q, addr_q, cmp_addr;
  logic [ADDR_W:0]   len_q, rem;      // rem = words still to issue after the current one
  logic [31:0]       pat, wd_q, cmp_exp;
  logic              cs_q, wr_q, cmp_vld;
  logic [3:0]        be_q;

`ifdef MEM_PATTERN_LFSR_EN
  function automatic logic [31:0] pat_next(input logic [31:0] p);
    pat_next = {1'b0, p[31:1]} ^ (p[0] ? 32'h8020_0003 : 32'h0);
  endfunction
`else
  function automatic logic [31:0] pat_next(input logic [31:0] p);
    pat_next = p + 32'd1;
  endfunction
`endif

  // Abort kills the bus in the same cycle; the FSM catches up at the next edge.
  assign mem.chipselect = cs_q & ~(abort & busy);
  assign mem.write      = wr_q & ~(abort & busy);
  assign mem.address    = addr_q;
  assign mem.byteenable = be_q;
  assign mem.writedata  = wd_q;
  assign mem.clken      = 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_count      <= '0;
      err_flag       <= 1'b0;
      first_err_addr <= '0;
      base_q         <= '0;
      len_q          <= '0;
      rem            <= '0;
      addr_q         <= '0;
      pat            <= SEED;
      wd_q           <= '0;
      cs_q           <= 1'b0;
      wr_q           <= 1'b0;
      be_q           <= 4'h0;
      cmp_vld        <= 1'b0;
      cmp_exp        <= '0;
      cmp_addr       <= '0;
    end else begin
      done <= 1'b0;
      if (busy && abort) begin
        // Drop the run and any in-flight compare; no done pulse.
        state   <= IDLE;
        busy    <= 1'b0;
        cs_q    <= 1'b0;
        wr_q    <= 1'b0;
        be_q    <= 4'h0;
        addr_q  <= '0;
        wd_q    <= '0;
        cmp_vld <= 1'b0;
      end else begin
        // Data for the read issued last cycle is on readdata now.
        if (cmp_vld) begin
          cmp_vld <= 1'b0;
          if (mem.readdata != cmp_exp) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            if (!err_flag) begin
              err_flag       <= 1'b1;
              first_err_addr <= cmp_addr;
            end
          end
        end
        case (state)
          IDLE: begin
            if (start && !abort) begin
              err_count      <= '0;
              err_flag       <= 1'b0;
              first_err_addr <= '0;
              if (length == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state  <= WRITE;
                busy   <= 1'b1;
                base_q <= base;
                len_q  <= length;
                rem    <= length - 1'b1;
                addr_q <= base;
                pat    <= SEED;
                wd_q   <= SEED;
                cs_q   <= 1'b1;
                wr_q   <= 1'b1;
                be_q   <= 4'hF;
              end
            end
          end
          WRITE: begin
            if (rem == '0) begin
              // Read phase replays the same sequence from SEED.
              state  <= READ;
              rem    <= len_q - 1'b1;
              addr_q <= base_q;
              pat    <= SEED;
              wd_q   <= '0;
              wr_q   <= 1'b0;
            end else begin
              rem    <= rem - 1'b1;
              addr_q <= addr_q + 1'b1;
              pat    <= pat_next(pat);
              wd_q   <= pat_next(pat);
            end
          end
          READ: begin
            cmp_vld  <= 1'b1;
            cmp_exp  <= pat;
            cmp_addr <= addr_q;
            if (rem == '0) begin
              state  <= DRAIN;
              cs_q   <= 1'b0;
              be_q   <= 4'h0;
              addr_q <= '0;
            end else begin
              rem    <= rem - 1'b1;
              addr_q <= addr_q + 1'b1;
              pat    <= pat_next(pat);
            end
          end
          DRAIN: begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_pattern_master.sv
module tb_mem_pattern_master;
  localparam int          AW   = 16;
  localparam logic [31:0] SEED = 32'h0000_0001;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, abort;
  logic [AW-1:0] base;
  logic [AW:0]   length;
  logic          busy, done, err_flag;
  logic [AW:0]   err_count;
  logic [AW-1:0] first_err_addr;

  mem_pattern_master_if #(.ADDR_W(AW)) mif ();

  mem_pattern_master #(.ADDR_W(AW), .SEED(SEED)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .base(base), .length(length), .busy(busy), .done(done),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .err_flag(err_flag), .mem(mif)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Memory model: 1-cycle registered read, optional bit-0 corruption on one address.
  logic [31:0]   mem_arr [0:(1<<AW)-1];
  logic          corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;

  always @(posedge clk) begin
    if (mif.chipselect && mif.write) mem_arr[mif.address] <= mif.writedata;
    if (mif.chipselect && !mif.write)
      mif.readdata <= mem_arr[mif.address] ^
                      ((corrupt_en && mif.address == corrupt_addr) ? 32'h1 : 32'h0);
  end

  function automatic logic [31:0] pat_of(input int i);
    logic [31:0] p;
    p = SEED;
    for (int k = 0; k < i; k++) begin
`ifdef MEM_PATTERN_LFSR_EN
      p = p[0] ? ((p >> 1) ^ 32'h8020_0003) : (p >> 1);
`else
      p = p + 32'd1;
`endif
    end
    return p;
  endfunction

  // Scoreboard of expected bus transactions, popped by the bus monitor.
  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } txn_t;
  txn_t sbq[$];
  bit   mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en && mif.chipselect) begin
      txn_t t;
      if (sbq.size() == 0) check("sb_extra_access", 32'(mif.address), 32'hFFFF_FFFF);
      else begin
        t = sbq.pop_front();
        check("sb_write", 32'(mif.write), 32'(t.wr));
        check("sb_addr", 32'(mif.address), 32'(t.addr));
        if (t.wr) begin
          check("sb_wdata", mif.writedata, t.data);
          check("sb_byteen", 32'(mif.byteenable), 32'hF);
        end
      end
    end
  end

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    bit            corrupt;
    logic [AW-1:0] caddr;
    int            exp_err;
    logic [AW-1:0] exp_first;
    bit            exp_flag;
    int            exp_lat;
  } vec_t;
  vec_t vecs[6];

  task automatic run_vec(input vec_t v);
    txn_t t;
    int   n;
    bit   got;
    corrupt_en   = v.corrupt;
    corrupt_addr = v.caddr;
    for (int i = 0; i < int'(v.len); i++) begin
      t.wr = 1'b1; t.addr = v.base + AW'(i); t.data = pat_of(i);
      sbq.push_back(t);
    end
    for (int i = 0; i < int'(v.len); i++) begin
      t.wr = 1'b0; t.addr = v.base + AW'(i); t.data = '0;
      sbq.push_back(t);
    end
    @(negedge clk);
    base = v.base; length = v.len; start = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'(v.len != 0));
      end
      if (done) got = 1'b1;
    end
    check("done_seen", 32'(got), 32'h1);
    check("done_latency", 32'(n), 32'(v.exp_lat));
    check("err_count", 32'(err_count), 32'(v.exp_err));
    check("err_flag", 32'(err_flag), 32'(v.exp_flag));
    check("first_err_addr", 32'(first_err_addr), 32'(v.exp_first));
    check("sb_leftover", 32'(sbq.size()), 32'h0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'h0);
    check("err_hold", 32'(err_count), 32'(v.exp_err));
    sbq.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_errcnt"}, 32'(err_count), 0);
    check({tag, "_errflag"}, 32'(err_flag), 0);
    check({tag, "_firsterr"}, 32'(first_err_addr), 0);
    check({tag, "_cs"}, 32'(mif.chipselect), 0);
    check({tag, "_wr"}, 32'(mif.write), 0);
    check({tag, "_be"}, 32'(mif.byteenable), 0);
    check({tag, "_addr"}, 32'(mif.address), 0);
    check({tag, "_wdata"}, mif.writedata, 0);
    check({tag, "_clken"}, 32'(mif.clken), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_w [3];
    bit          dseen;
    int          n;
    bit          got;

    vecs[0] = '{16'h0010, 17'd4, 1'b0, 16'h0000, 0, 16'h0000, 1'b0, 10};
    vecs[1] = '{16'hFFFE, 17'd4, 1'b0, 16'h0000, 0, 16'h0000, 1'b0, 10};
    vecs[2] = '{16'h0010, 17'd8, 1'b1, 16'h0012, 1, 16'h0012, 1'b1, 18};
    vecs[3] = '{16'h0000, 17'd0, 1'b0, 16'h0000, 0, 16'h0000, 1'b0, 1};
    vecs[4] = '{16'h0100, 17'd3, 1'b0, 16'h0000, 0, 16'h0000, 1'b0, 8};
    vecs[5] = '{16'h0020, 17'd5, 1'b1, 16'h0024, 1, 16'h0024, 1'b1, 12};

    reset_n = 1'b0; start = 1'b0; abort = 1'b0; base = '0; length = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);
    mon_en = 1'b0;

    // Pattern values on the bus for a 3-word run.
`ifdef MEM_PATTERN_LFSR_EN
    exp_w[0] = 32'h0000_0001; exp_w[1] = 32'h8020_0003; exp_w[2] = 32'hC030_0002;
`else
    exp_w[0] = 32'h0000_0001; exp_w[1] = 32'h0000_0002; exp_w[2] = 32'h0000_0003;
`endif
    corrupt_en = 1'b0;
    @(negedge clk);
    base = 16'h0200; length = 17'd3; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      check("pattern_wdata", mif.writedata, exp_w[i]);
    end
    n = 0; got = 1'b0;
    while (!got && n < 50) begin
      @(negedge clk); n++;
      if (done) got = 1'b1;
    end
    check("pattern_done", 32'(got), 1);
    check("pattern_errcnt", 32'(err_count), 0);

    // Abort on the 3rd WRITE cycle.
    @(negedge clk);
    base = 16'h0040; length = 17'd6; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_pre_cs", 32'(mif.chipselect), 1);
    abort = 1'b1;
    #1;
    check("abort_cs_gated", 32'(mif.chipselect), 0);
    check("abort_wr_gated", 32'(mif.write), 0);
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy_next", 32'(busy), 0);
    check("abort_cs_next", 32'(mif.chipselect), 0);
    dseen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) dseen = 1'b1;
    end
    check("abort_no_done", 32'(dseen), 0);
    mon_en = 1'b1;
    run_vec(vecs[0]);
    mon_en = 1'b0;

    // Reset in the middle of READ after one mismatch has been counted.
    corrupt_en = 1'b1; corrupt_addr = 16'h0012;
    @(negedge clk);
    base = 16'h0010; length = 17'd8; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (13) @(negedge clk);
    check("midread_busy", 32'(busy), 1);
    check("midread_errcnt", 32'(err_count), 1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midread_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    dseen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done) dseen = 1'b1;
    end
    check("reset_no_done", 32'(dseen), 0);
    mon_en = 1'b1;
    run_vec(vecs[0]);
    mon_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
